dpwm_deadtime: RTL and testbench
================================

Name: dpwm_deadtime

Overview:
Digital PWM back end for the buck converter. It consumes the 10-bit duty command produced by the PID compensator and drives complementary high-side and low-side gate signals with programmable dead time. It also generates period-aligned strobes that pace the error sampling and compensator update. Duty is double-buffered so that it changes only on period boundaries.

Parameters:
N_BITS, 10, counter and duty width; switching period = 2^N_BITS clk cycles
DEAD_CYCLES, 4, dead time in clk cycles inserted at every switch transition; must be >= 1
D_MAX, 972, upper clamp on the latched duty
SAMPLE_POINT, 512, counter value at which adc_trig fires

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  run request; 0 = converter off
d_n_input  input  N_BITS  duty command from the compensator, unsigned
pwm_hs  output  1  high-side gate drive
pwm_ls  output  1  low-side gate drive
duty_active  output  N_BITS  duty value used in the current period
period_start  output  1  high for the cnt==0 cycle
adc_trig  output  1  high for the cnt==SAMPLE_POINT cycle

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: cnt=0, d_lat=0, state=IDLE, dt_cnt=0. pwm_hs, pwm_ls, period_start and adc_trig are 0; duty_active is 0. Reset has priority over all other conditions.
- Reset mid-operation: both gate outputs are low from the next edge.
- Counter:
  - cnt <= enable ? cnt+1 : 0.
  - Wraps from 2^N-1 to 0.
- Clamp: clamp(x) = (x > D_MAX) ? D_MAX : x.
- Duty latch (d_lat):
  - If enable=0: d_lat <= clamp(d_n_input) every cycle.
  - If enable=1: d_lat loads only in the cycle where cnt==2^N-1.
  - Changes to d_n_input in mid-period are ignored until the next boundary.
  - duty_active = d_lat.
- Raw compare: raw = (cnt < d_lat), combinational.
- FSM states: IDLE, DT, HS_ON, LS_ON.
  - Outputs decode from the state register: pwm_hs = (state==HS_ON), pwm_ls = (state==LS_ON). In IDLE and DT both outputs are 0.
  - The two outputs are never high together.
- FSM transitions, evaluated at each edge using the current cycle's raw:
  - Any state with enable=0 -> IDLE.
  - IDLE with enable=1 -> DT, dt_cnt <= DEAD_CYCLES-1.
  - HS_ON with raw=0 -> DT, with the same dt_cnt load.
  - LS_ON with raw=1 -> DT, with the same dt_cnt load.
  - DT with dt_cnt != 0 -> DT, dt_cnt-1.
  - DT with dt_cnt == 0 -> HS_ON if raw, else LS_ON.
  - raw toggling during DT has no effect until DT expires.
- Steady-state timing with D = d_lat:
  - DEAD < D < 2^N-DEAD: pwm_hs high for cnt DEAD+1..D, i.e. D-DEAD cycles. pwm_ls high from cnt D+DEAD+1 through cnt 0 of the next period, i.e. 2^N-D-DEAD cycles. Exactly DEAD both-low cycles sit on each side.
  - 1 <= D <= DEAD: the high-side pulse is swallowed; pwm_hs stays 0. pwm_ls is low only for cnt 1..DEAD.
  - D = 0: pwm_ls is continuously high after the initial DT.
- Enable rising: the cycle with enable=1 has cnt=0. DT runs for cnt 1..DEAD, and the first pwm_hs rise is at cnt = DEAD+1 (when d_lat > DEAD).
- Enable falling: both outputs are 0 from the next edge, including when this happens during HS_ON or DT.
- Strobes:
  - period_start = enable & (cnt==0).
  - adc_trig = enable & (cnt==SAMPLE_POINT).
  - Both are decoded from the cnt register, one cycle wide, once per period.

Test Plan:
1. Assert reset for 3 cycles with enable=1, d_n_input=512 -> pwm_hs=pwm_ls=0, duty_active=0, period_start=0 throughout reset.
2. enable=1, d_n_input=512, DEAD=4 -> each 1024-cycle period: pwm_hs high 508 cycles (cnt 5..512), 4 both-low cycles, pwm_ls high 508 cycles, 4 both-low cycles. Never both high.
3. d_n_input=1000 -> duty_active=972; pwm_hs high 968 cycles per period; pwm_ls high 48.
4. d_n_input changes 512->256 at cnt=100 -> current period keeps 508 hs cycles. duty_active=256 from cnt=0 of the next period, then 252 hs cycles.
5. d_n_input=3 -> pwm_hs never high; pwm_ls low only for cnt 1..4 (1020 high cycles). d_n_input=0 -> pwm_ls continuously high.
6. Drop enable during HS_ON at cnt=300 -> both outputs 0 next cycle, cnt=0. Re-enable -> first pwm_hs rise at cnt=5, with period_start and adc_trig (cnt 512) each pulsing once per period.

Source files
------------

// File: rtl/dpwm_deadtime.sv
// Complementary PWM generator with dead-time insertion, period-boundary duty buffering
// and period-aligned strobes for ADC sampling and compensator pacing.
module dpwm_deadtime #(
   parameter int N_BITS       = 10,
   parameter int DEAD_CYCLES  = 4,
   parameter int D_MAX        = 972,
   parameter int SAMPLE_POINT = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [N_BITS-1:0] d_n_input,
   output logic              pwm_hs,
   output logic              pwm_ls,
   output logic [N_BITS-1:0] duty_active,
   output logic              period_start,
   output logic              adc_trig
);

   localparam int                DT_W      = $clog2(DEAD_CYCLES + 1);
   localparam logic [N_BITS-1:0] CNT_MAX   = '1;
   localparam logic [N_BITS-1:0] D_MAX_V   = N_BITS'(D_MAX);
   localparam logic [N_BITS-1:0] SAMPLE_V  = N_BITS'(SAMPLE_POINT);
   localparam logic [DT_W-1:0]   DT_LOAD   = DT_W'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DT, HS_ON, LS_ON} state_t;

   state_t            state;
   logic [N_BITS-1:0] cnt;
   logic [N_BITS-1:0] d_lat;
   logic [DT_W-1:0]   dt_cnt;
   logic              raw;

   function automatic logic [N_BITS-1:0] clamp(input logic [N_BITS-1:0] x);
      return (x > D_MAX_V) ? D_MAX_V : x;
   endfunction

   assign raw = (cnt < d_lat);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         d_lat  <= '0;
         state  <= IDLE;
         dt_cnt <= '0;
      end else begin
         cnt <= enable ? cnt + 1'b1 : '0;

         // While stopped the latch tracks the command so the first period starts with it.
         if (!enable || cnt == CNT_MAX)
            d_lat <= clamp(d_n_input);

         if (!enable) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  state  <= DT;
                  dt_cnt <= DT_LOAD;
               end
               DT: begin
                  if (dt_cnt != '0)
                     dt_cnt <= dt_cnt - 1'b1;
                  else
                     state <= raw ? HS_ON : LS_ON;
               end
               HS_ON: begin
                  if (!raw) begin
                     state  <= DT;
                     dt_cnt <= DT_LOAD;
                  end
               end
               LS_ON: begin
                  if (raw) begin
                     state  <= DT;
                     dt_cnt <= DT_LOAD;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign pwm_hs      = (state == HS_ON);
   assign pwm_ls      = (state == LS_ON);
   assign duty_active = d_lat;

   // Strobes are held quiet while reset is asserted even though cnt already reads 0.
   assign period_start = enable & ~reset & (cnt == '0);
   assign adc_trig     = enable & ~reset & (cnt == SAMPLE_V);

endmodule

// File: tb/tb_dpwm_deadtime.sv
// Bench for dpwm_deadtime: positional reference model checked every cycle,
// directed period measurements with literal counts, then randomized stimulus.
module tb_dpwm_deadtime;

   localparam int NB    = 10;
   localparam int PER   = 1 << NB;
   localparam int DEAD  = 4;
   localparam int DMAX  = 972;
   localparam int SAMP  = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [NB-1:0] d_n_input;
   logic          pwm_hs;
   logic          pwm_ls;
   logic [NB-1:0] duty_active;
   logic          period_start;
   logic          adc_trig;

   int checks = 0;
   int errors = 0;

   dpwm_deadtime #(
      .N_BITS(NB), .DEAD_CYCLES(DEAD), .D_MAX(DMAX), .SAMPLE_POINT(SAMP)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .d_n_input(d_n_input),
      .pwm_hs(pwm_hs), .pwm_ls(pwm_ls), .duty_active(duty_active),
      .period_start(period_start), .adc_trig(adc_trig)
   );

   always #5 clk = ~clk;

   // Reference model: position in the period, active duty, whether running,
   // and whether this is the first period after start-up.
   int m_cnt   = 0;
   int m_d     = 0;
   bit m_on    = 0;
   bit m_first = 0;
   bit chk_on  = 0;

   function automatic int clampi(input int x);
      return (x > DMAX) ? DMAX : x;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_cnt = 0; m_d = 0; m_on = 0; m_first = 0;
      end else if (enable) begin
         if (m_cnt == PER - 1) m_d = clampi(int'(d_n_input));
         if (!m_on) m_first = 1;
         else if (m_cnt == PER - 1) m_first = 0;
         m_cnt = (m_cnt + 1) % PER;
         m_on  = 1;
      end else begin
         m_cnt = 0; m_d = clampi(int'(d_n_input)); m_on = 0; m_first = 0;
      end
      chk_on = 1;
   end

   function automatic bit exp_hs();
      if (!m_on || m_cnt <= DEAD) return 0;
      if (m_d > DEAD) return (m_cnt <= m_d);
      return 0;
   endfunction

   function automatic bit exp_ls();
      if (!m_on) return 0;
      if (m_cnt == 0) return 1;
      if (m_cnt <= DEAD) return (m_d == 0 && !m_first);
      if (m_d > DEAD) return (m_cnt >= m_d + DEAD + 1);
      return 1;
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors < 40)
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         cmp("pwm_hs", int'(pwm_hs), int'(exp_hs()));
         cmp("pwm_ls", int'(pwm_ls), int'(exp_ls()));
         cmp("duty_active", int'(duty_active), m_d);
         cmp("period_start", int'(period_start), int'(enable && !reset && m_cnt == 0));
         cmp("adc_trig", int'(adc_trig), int'(enable && !reset && m_cnt == SAMP));
         cmp("overlap", int'(pwm_hs && pwm_ls), 0);
      end
   end

   // Period measurement aligned on period_start; optionally changes the duty mid-period.
   int g_hs, g_ls, g_ps, g_adc, g_rise, g_duty0;

   task automatic measure(input int change_at, input int new_d);
      bit found = 0;
      bit prev_hs = 0;
      for (int k = 0; k < 3000 && !found; k++) begin
         @(negedge clk);
         if (period_start) found = 1;
      end
      if (!found) begin
         cmp("period_start_timeout", 0, 1);
         return;
      end
      g_hs = 0; g_ls = 0; g_ps = 0; g_adc = 0; g_rise = -1;
      g_duty0 = int'(duty_active);
      for (int i = 0; i < PER; i++) begin
         if (i > 0) @(negedge clk);
         g_hs  += int'(pwm_hs);
         g_ls  += int'(pwm_ls);
         g_ps  += int'(period_start);
         g_adc += int'(adc_trig);
         if (pwm_hs && !prev_hs && g_rise < 0) g_rise = i;
         prev_hs = pwm_hs;
         if (i == change_at) d_n_input = NB'(new_d);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; d_n_input = 10'd512;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         cmp("rst_hs", int'(pwm_hs), 0);
         cmp("rst_ls", int'(pwm_ls), 0);
         cmp("rst_duty", int'(duty_active), 0);
         cmp("rst_ps", int'(period_start), 0);
      end
      @(posedge clk); #2 reset = 1'b0;

      measure(-1, 0);
      measure(-1, 0);
      cmp("d512_hs", g_hs, 508);
      cmp("d512_ls", g_ls, 508);
      cmp("d512_rise", g_rise, 5);
      cmp("d512_ps", g_ps, 1);
      cmp("d512_adc", g_adc, 1);

      measure(100, 256);
      cmp("midchg_hs", g_hs, 508);
      measure(-1, 0);
      cmp("d256_duty", g_duty0, 256);
      cmp("d256_hs", g_hs, 252);
      cmp("d256_ls", g_ls, 764);

      measure(0, 1000);
      measure(-1, 0);
      cmp("clamp_duty", g_duty0, 972);
      cmp("clamp_hs", g_hs, 968);
      cmp("clamp_ls", g_ls, 48);

      measure(0, 3);
      measure(-1, 0);
      cmp("d3_hs", g_hs, 0);
      cmp("d3_ls", g_ls, 1020);

      measure(0, 0);
      measure(-1, 0);
      cmp("d0_hs", g_hs, 0);
      cmp("d0_ls", g_ls, 1024);

      measure(0, 512);
      repeat (301) @(posedge clk);
      #2 enable = 1'b0;
      @(negedge clk);
      cmp("drop_hs_before", int'(pwm_hs), 1);
      @(negedge clk);
      cmp("drop_hs", int'(pwm_hs), 0);
      cmp("drop_ls", int'(pwm_ls), 0);
      repeat (5) @(posedge clk);
      #2 enable = 1'b1;
      measure(-1, 0);
      cmp("reen_rise", g_rise, 5);
      cmp("reen_hs", g_hs, 508);
      cmp("reen_ls", g_ls, 507);
      cmp("reen_ps", g_ps, 1);
      cmp("reen_adc", g_adc, 1);

      // Randomized run: sparse enable toggles and resets, frequent duty changes.
      for (int n = 0; n < 20000; n++) begin
         @(posedge clk); #2;
         reset = ($urandom_range(0, 3999) == 0);
         if ($urandom_range(0, 1499) == 0) enable = ~enable;
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 2))
               0:       d_n_input = NB'($urandom_range(0, 8));
               1:       d_n_input = NB'($urandom_range(965, 1023));
               default: d_n_input = NB'($urandom_range(0, 1023));
            endcase
         end
      end
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
